blockade_vram_arbiter: RTL and testbench

//  Shares one single-port 1Kx8 video RAM between the video tile fetch and CPU reads and writes.
//  It replaces the dual-port VRAM and the U9 READY logic in the Blockade/CoMotion/Hustle/Blasto core.

---
 rtl/blockade_pkg.sv | 13 +
 rtl/spram.sv | 23 ++
 rtl/blockade_vram_arbiter.sv | 105 ++++++++++
 tb/tb_blockade_vram_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blockade_pkg.sv
// Shared types and sizes for the Blockade-family video RAM path.
package blockade_pkg;

    localparam int VRAM_AW = 10;
    localparam int VRAM_DW = 8;

    typedef enum logic [1:0] {
        VA_IDLE,
        VA_ACCESS,
        VA_HOLD
    } vram_arb_state_t;

endpackage

// File: rtl/spram.sv
// Single-port synchronous RAM with a registered read port (read-before-write).
module spram #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [2**AW];

    // NOTE: the array has no reset so it maps onto block RAM; power-up contents are undefined.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= d;
        end
        q <= mem[addr];
    end

endmodule

// File: rtl/blockade_vram_arbiter.sv
// Shares one single-port VRAM between video tile fetch (always wins) and CPU access.
// Define BLOCKADE_VRAM_ACTIVE_WRITE_EN to let CPU writes through during active display.
module blockade_vram_arbiter
    import blockade_pkg::*;
#(
    parameter int AW  = VRAM_AW,
    parameter int DW  = VRAM_DW,
    parameter int SCW = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ce_vid,
    input  logic           vblank_n,
    input  logic [AW-1:0]  vid_addr,
    output logic [DW-1:0]  vid_data,
    input  logic           cpu_req,
    input  logic           cpu_we,
    input  logic [AW-1:0]  cpu_addr,
    input  logic [DW-1:0]  cpu_wdata,
    output logic [DW-1:0]  cpu_rdata,
    output logic           cpu_ack,
    output logic           cpu_ready,
    output logic [SCW-1:0] stall_count
);

    vram_arb_state_t state, next_state;

    logic          allowed;
    logic          grant;
    logic          access_we;
    logic          vid_pending;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
`ifdef BLOCKADE_VRAM_ACTIVE_WRITE_EN
        allowed = 1'b1;
`else
        allowed = ~cpu_we | ~vblank_n;
`endif
        grant      = 1'b0;
        next_state = state;
        case (state)
            VA_IDLE: begin
                if (cpu_req && !ce_vid && allowed) begin
                    grant      = 1'b1;
                    next_state = VA_ACCESS;
                end
            end
            VA_ACCESS: next_state = VA_HOLD;
            VA_HOLD:   if (!cpu_req) next_state = VA_IDLE;
            default:   next_state = VA_IDLE;
        endcase
        // The RAM port belongs to video unless the CPU is granted this very cycle.
        ram_addr = grant ? cpu_addr : vid_addr;
        ram_we   = grant & cpu_we;
    end

    assign cpu_ready = ~(cpu_req & ~cpu_ack);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= VA_IDLE;
            cpu_ack     <= 1'b0;
            cpu_rdata   <= '0;
            vid_data    <= '0;
            vid_pending <= 1'b0;
            access_we   <= 1'b0;
            stall_count <= '0;
        end else begin
            state       <= next_state;
            vid_pending <= ce_vid;
            if (vid_pending) begin
                vid_data <= ram_q;
            end
            if (grant) begin
                access_we <= cpu_we;
            end
            if (state == VA_ACCESS) begin
                cpu_ack <= 1'b1;
                if (!access_we) begin
                    cpu_rdata <= ram_q;
                end
            end
            if (state == VA_HOLD && !cpu_req) begin
                cpu_ack <= 1'b0;
            end
            if (cpu_req && !cpu_ack && state == VA_IDLE && stall_count != '1) begin
                stall_count <= stall_count + SCW'(1);
            end
        end
    end

    spram #(.AW(AW), .DW(DW)) u_vram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .d    (cpu_wdata),
        .q    (ram_q)
    );

endmodule

// File: tb/tb_blockade_vram_arbiter.sv
// Scoreboard bench for blockade_vram_arbiter: directed cases plus randomized CPU/video traffic.
module tb_blockade_vram_arbiter;
    import blockade_pkg::*;

    localparam int AW    = VRAM_AW;
    localparam int DW    = VRAM_DW;
    localparam int SCW   = 16;
    localparam int NPOOL = 18;

    logic           clk = 1'b0;
    logic           reset;
    logic           ce_vid;
    logic           vblank_n;
    logic [AW-1:0]  vid_addr;
    logic [DW-1:0]  vid_data;
    logic           cpu_req;
    logic           cpu_we;
    logic [AW-1:0]  cpu_addr;
    logic [DW-1:0]  cpu_wdata;
    logic [DW-1:0]  cpu_rdata;
    logic           cpu_ack;
    logic           cpu_ready;
    logic [SCW-1:0] stall_count;

    blockade_vram_arbiter #(.AW(AW), .DW(DW), .SCW(SCW)) dut (
        .clk         (clk),
        .reset       (reset),
        .ce_vid      (ce_vid),
        .vblank_n    (vblank_n),
        .vid_addr    (vid_addr),
        .vid_data    (vid_data),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ack     (cpu_ack),
        .cpu_ready   (cpu_ready),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    req_t          exp_q[$];
    logic [DW-1:0] model_mem [1 << AW];
    logic [AW-1:0] pool [NPOOL];

    bit vid_auto  = 1'b0;
    bit vb_auto   = 1'b0;
    int vid_phase = 0;
    int vb_cnt    = 0;
    int vb_len    = 10;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic          vid_s0 = 1'b0, vid_s1 = 1'b0;
    logic [AW-1:0] va_s0, va_s1;
    logic          prev_ack = 1'b0;
    req_t          mon_r;

    always @(posedge clk) begin
        if (reset) begin
            vid_s0 <= 1'b0;
            vid_s1 <= 1'b0;
        end else begin
            vid_s0 <= ce_vid;
            va_s0  <= vid_addr;
            vid_s1 <= vid_s0;
            va_s1  <= va_s0;
        end
    end

    always @(negedge clk) begin
        if (vid_s1) begin
            check("vid_data", vid_data, model_mem[va_s1]);
        end
        if (cpu_ack && !prev_ack) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: cpu_ack rose with no outstanding request");
            end else begin
                mon_r = exp_q.pop_front();
                if (mon_r.we) begin
                    model_mem[mon_r.addr] <= mon_r.wdata;
                end else begin
                    check("cpu_rdata", cpu_rdata, model_mem[mon_r.addr]);
                end
            end
        end
        prev_ack <= cpu_ack;
    end

    // Requester must hold its command stable from cpu_req rise until cpu_ack.
    logic                hold_d = 1'b0;
    logic [AW+DW:0]      hold_v;
    always @(negedge clk) begin
        if (!reset && hold_d && cpu_req && !cpu_ack) begin
            assert ({cpu_we, cpu_addr, cpu_wdata} == hold_v)
                else $error("requester changed command before cpu_ack");
        end
        hold_d <= cpu_req && !cpu_ack;
        hold_v <= {cpu_we, cpu_addr, cpu_wdata};
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (vid_auto) begin
            vid_phase = (vid_phase + 1) % 4;
            ce_vid    = (vid_phase == 0);
            vid_addr  = pool[$urandom_range(0, NPOOL - 1)];
        end else begin
            ce_vid = 1'b0;
        end
        if (vb_auto) begin
            vb_cnt++;
            if (vb_cnt >= vb_len) begin
                vb_cnt   = 0;
                vb_len   = $urandom_range(4, 40);
                vblank_n = ~vblank_n;
            end
        end
    endtask

    // Issues one access; checks grant at the first permitted edge and the stall delta.
    task automatic do_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                             input int budget, output int cycles, output bit got);
        bit ok_e [256];
        int first_ok;
        int stall_before;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_req   = 1'b1;
        exp_q.push_back('{we: we, addr: addr, wdata: wdata});
        stall_before = int'(stall_count);
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles < budget) begin
`ifdef BLOCKADE_VRAM_ACTIVE_WRITE_EN
            ok_e[cycles + 1] = !ce_vid;
`else
            ok_e[cycles + 1] = !ce_vid && (!we || !vblank_n);
`endif
            tick();
            @(negedge clk);
            cycles++;
            if (cpu_ack) got = 1'b1;
            else check("cpu_ready_while_waiting", cpu_ready, 0);
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_timeout: no cpu_ack after %0d cycles, required within %0d", cycles, budget);
        end else begin
            first_ok = 0;
            for (int k = cycles - 1; k >= 1; k--) if (ok_e[k]) first_ok = k;
            check("grant_edge", cycles - 1, first_ok);
            check("stall_delta", int'(stall_count) - stall_before, cycles - 1);
        end
    endtask

    task automatic release_req();
        cpu_req = 1'b0;
        tick();
        @(negedge clk);
        check("ack_after_release", cpu_ack, 0);
        check("ready_after_release", cpu_ready, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        vid_auto = 1'b0;
        reset    = 1'b1;
        cpu_req  = 1'b0;
        tick();
        @(negedge clk);
        exp_q.delete();
        reset = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bit  got;
        bit  early;
        logic we;
        logic [AW-1:0] a;

        for (int i = 0; i < 16; i++) pool[i] = AW'(12'h150 + i);
        pool[16] = 10'h010;
        pool[17] = 10'h020;

        reset = 1'b1; ce_vid = 1'b0; vblank_n = 1'b1; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

        // 1: reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_vid_data", vid_data, 0);
        check("reset_cpu_ack", cpu_ack, 0);
        check("reset_cpu_ready", cpu_ready, 1);
        check("reset_stall_count", stall_count, 0);
        reset = 1'b0;

        // Preload every address used later, during vertical blank.
        vblank_n = 1'b0;
        for (int i = 0; i < NPOOL; i++) begin
            logic [DW-1:0] dv;
            dv = (pool[i] == 10'h155) ? 8'hA5 : (pool[i] == 10'h010) ? 8'h07 : DW'($urandom);
            do_access(1'b1, pool[i], dv, 10, cyc, got);
            release_req();
        end
        vblank_n = 1'b1;

        // 2: read in a free cycle -> ack one edge after the grant edge
        do_access(1'b0, 10'h155, 8'h00, 10, cyc, got);
        check("t2_read_latency", cyc, 2);
        check("t2_rdata", cpu_rdata, 8'hA5);
        release_req();

        // 3: collision with a video slot; video wins, CPU granted on the next edge
        ce_vid   = 1'b1;
        vid_addr = 10'h010;
        do_access(1'b0, 10'h155, 8'h00, 10, cyc, got);
        check("t3_collision_latency", cyc, 3);
        check("t3_vid_data", vid_data, 8'h07);
        check("t3_rdata", cpu_rdata, 8'hA5);
        release_req();

        do_reset();
        vblank_n = 1'b1;
`ifdef BLOCKADE_VRAM_ACTIVE_WRITE_EN
        // 5: active-display write goes straight through
        do_access(1'b1, 10'h020, 8'h3C, 2, cyc, got);
        check("t5_ack_within_2", got && cyc <= 2, 1);
        check("t5_stall_le1", stall_count <= 1, 1);
        release_req();
`else
        // 4: active-display write stalls until vertical blank
        cpu_we = 1'b1; cpu_addr = 10'h020; cpu_wdata = 8'h3C; cpu_req = 1'b1;
        exp_q.push_back('{we: 1'b1, addr: 10'h020, wdata: 8'h3C});
        early = 1'b0;
        repeat (100) begin
            tick();
            @(negedge clk);
            if (cpu_ack) early = 1'b1;
        end
        check("t4_no_ack_active", early, 0);
        check("t4_stall_100", stall_count, 100);
        check("t4_ready_low", cpu_ready, 0);
        vblank_n = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 2 && !got; k++) begin
            tick();
            @(negedge clk);
            if (cpu_ack) got = 1'b1;
        end
        check("t4_ack_in_vblank", got, 1);
        release_req();
        vblank_n = 1'b1;
`endif
        ce_vid   = 1'b1;
        vid_addr = 10'h020;
        tick();
        tick();
        @(negedge clk);
        check("t4_fetch_written", vid_data, 8'h3C);

        // 6: reset while a write is pending in active display
        cpu_we = 1'b1; cpu_addr = 10'h030; cpu_wdata = 8'h99; cpu_req = 1'b1;
        exp_q.push_back('{we: 1'b1, addr: 10'h030, wdata: 8'h99});
        repeat (5) tick();
        do_reset();
        check("t6_ack_after_reset", cpu_ack, 0);
        check("t6_stall_after_reset", stall_count, 0);
        check("t6_vid_data_after_reset", vid_data, 0);
        do_access(1'b0, 10'h155, 8'h00, 10, cyc, got);
        check("t6_read_latency", cyc, 2);
        release_req();

        // Random traffic: periodic video slots, toggling vblank, random CPU reads/writes.
        vid_auto = 1'b1;
        vb_auto  = 1'b1;
        for (int n = 0; n < 250; n++) begin
            we = 1'($urandom_range(0, 1));
            a  = pool[$urandom_range(0, NPOOL - 1)];
            do_access(we, a, DW'($urandom), 120, cyc, got);
            if (!we) check("rand_read_latency_le3", cyc <= 3, 1);
            release_req();
            repeat ($urandom_range(0, 2)) tick();
        end
        vid_auto = 1'b0;
        vb_auto  = 1'b0;
        repeat (4) tick();
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
